id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter RW, default 5, register-index width.
REQ-003 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, asynchronous active-high reset), listed first.
REQ-004 SHALL have ID inputs id_valid (1), id_pc (XLEN), id_rs1_data and id_rs2_data (XLEN), id_imm (XLEN), id_rs1, id_rs2, id_rd (RW).
REQ-005 SHALL have ID inputs id_uses_rs1 and id_uses_rs2 (1 each).
REQ-006 SHALL have ID control inputs id_reg_write, id_mem_read, id_mem_write, id_alu_src (1 each), id_wb_sel (2), id_alu_op (4).
REQ-007 SHALL have hazard inputs stall (1, hold stage) and flush (1, kill stage contents).
REQ-008 SHALL have forwarding inputs exmem_rd and memwb_rd (RW), plus exmem_reg_write and memwb_reg_write (1 each).
REQ-009 SHALL have registered outputs ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_wb_sel, ex_alu_op, with widths matching the corresponding id_* inputs.
REQ-010 SHALL have outputs fwd_a_sel and fwd_b_sel (2 each), which drive the EX-stage 4:1 operand muxes.
REQ-011 SHALL have output load_use_stall (1), which requests an IF/ID hold.

Function
REQ-012 SHALL apply one update rule at each rising clk edge, highest priority first: flush, stall, load_use_stall, load.
REQ-013 On flush, SHALL insert a bubble: ex_valid, ex_reg_write, ex_mem_read and ex_mem_write cleared; other fields don't-care but SHALL be zeroed.
REQ-014 On stall without flush, SHALL hold every register.
REQ-015 On load_use_stall without stall or flush, SHALL insert a bubble as in REQ-013.
REQ-016 Otherwise SHALL capture all id_* inputs into the ex_* registers, one-cycle latency.
REQ-017 SHALL drive load_use_stall combinationally as: ex_valid and ex_mem_read and ex_rd != 0 and ((id_uses_rs1 and id_rs1 == ex_rd) or (id_uses_rs2 and id_rs2 == ex_rd)) and id_valid.
REQ-018 SHALL use forward encoding 0 = register-file data, 1 = EX/MEM ALU result, 2 = MEM/WB writeback data, 3 = alternate source (PC for A, immediate for B).
REQ-019 SHALL compute fwd_a_sel combinationally from the registered ex_rs1; fwd_b_sel likewise from ex_rs2.
REQ-020 Forward select SHALL be 1 if exmem_reg_write and exmem_rd == src and src != 0.
REQ-021 Else forward select SHALL be 2 if memwb_reg_write and memwb_rd == src and src != 0.
REQ-022 Else forward select SHALL be 0; EX/MEM always wins over MEM/WB.
REQ-023 SHALL force fwd_b_sel to 3 when ex_alu_src = 1, overriding forwarding.
REQ-024 fwd_a_sel SHALL equal 3 only when ex_wb_sel = 2'd3 (AUIPC/JAL PC operand).
REQ-025 Register x0 SHALL never be forwarded; selects SHALL read 0 for src = 0.
REQ-026 When ex_valid = 0, SHALL drive fwd_a_sel = fwd_b_sel = 0.

Reset
REQ-027 Asserting rst SHALL immediately zero every ex_* register regardless of clk, giving fwd_*_sel = 0 and load_use_stall = 0.
REQ-028 Deasserting rst mid-stream SHALL resume with the first edge loading id_* per REQ-012.

Structure
REQ-029 SHALL take the forward-select encodings (FWD_REG, FWD_EXMEM, FWD_MEMWB, FWD_ALT) and the WB_SEL codes from shared package riscv_pkg.
REQ-030 SHALL instantiate comparator sub-module fwd_sel twice (operands A and B): inputs src, exmem/memwb rd and write-enables; output 2-bit select.

Verification
REQ-031 SHALL bench-test dependency: ex_rs1 = 5, exmem_rd = 5, exmem_reg_write = 1, memwb_rd = 5, memwb_reg_write = 1 -> fwd_a_sel = 1.
REQ-032 SHALL bench-test x0: ex_rs2 = 0, exmem_rd = 0, exmem_reg_write = 1, ex_alu_src = 0 -> fwd_b_sel = 0.
REQ-033 SHALL bench-test load-use: EX holds lw x7 (ex_mem_read = 1), id_rs1 = 7, id_uses_rs1 = 1 -> load_use_stall = 1; next edge ex_valid = 0 and ex_reg_write = 0.
REQ-034 SHALL bench-test priority: stall = 1 and flush = 1 together -> bubble; stall alone for 3 cycles -> ex_pc unchanged (e.g. 0x00000040).
REQ-035 SHALL bench-test immediate: ex_alu_src = 1 and exmem_rd == ex_rs2 -> fwd_b_sel = 3.
REQ-036 SHALL bench-test reset: rst pulsed between clk edges with ex_valid = 1 -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared operand-forwarding and writeback-select codes
package riscv_pkg;

   typedef logic [1:0] fwd_t;
   typedef logic [1:0] wb_sel_t;

   localparam fwd_t FWD_REG   = 2'd0;
   localparam fwd_t FWD_EXMEM = 2'd1;
   localparam fwd_t FWD_MEMWB = 2'd2;
   localparam fwd_t FWD_ALT   = 2'd3;

   localparam wb_sel_t WB_ALU = 2'd0;
   localparam wb_sel_t WB_MEM = 2'd1;
   localparam wb_sel_t WB_PC4 = 2'd2;
   localparam wb_sel_t WB_PC  = 2'd3;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - forwarding comparator for one EX source operand
module fwd_sel
   import riscv_pkg::*;
#(
   parameter int RW = 5
) (
   input  logic [RW-1:0] src,
   input  logic [RW-1:0] exmem_rd,
   input  logic          exmem_reg_write,
   input  logic [RW-1:0] memwb_rd,
   input  logic          memwb_reg_write,
   output logic [1:0]    sel
);

   // The younger EX/MEM result shadows MEM/WB; x0 is hardwired and never forwarded.
   always_comb begin
      sel = FWD_REG;
      if (src != '0) begin
         if (exmem_reg_write && (exmem_rd == src))
            sel = FWD_EXMEM;
         else if (memwb_reg_write && (memwb_rd == src))
            sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding selects and load-use detection
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [RW-1:0]   id_rs1,
   input  logic [RW-1:0]   id_rs2,
   input  logic [RW-1:0]   id_rd,
   input  logic            id_uses_rs1,
   input  logic            id_uses_rs2,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            id_alu_src,
   input  logic [1:0]      id_wb_sel,
   input  logic [3:0]      id_alu_op,
   input  logic            stall,
   input  logic            flush,
   input  logic [RW-1:0]   exmem_rd,
   input  logic [RW-1:0]   memwb_rd,
   input  logic            exmem_reg_write,
   input  logic            memwb_reg_write,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [RW-1:0]   ex_rs1,
   output logic [RW-1:0]   ex_rs2,
   output logic [RW-1:0]   ex_rd,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_alu_src,
   output logic [1:0]      ex_wb_sel,
   output logic [3:0]      ex_alu_op,
   output logic [1:0]      fwd_a_sel,
   output logic [1:0]      fwd_b_sel,
   output logic            load_use_stall
);

   logic [1:0] fwd_a_raw;
   logic [1:0] fwd_b_raw;
   logic       bubble;

   // A load in EX cannot feed the instruction in ID in time; hold ID and bubble EX.
   assign load_use_stall = ex_valid && ex_mem_read && (ex_rd != '0) &&
                           ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                            (id_uses_rs2 && (id_rs2 == ex_rd))) && id_valid;

   assign bubble = flush || (!stall && load_use_stall);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_imm       <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_alu_src   <= 1'b0;
         ex_wb_sel    <= '0;
         ex_alu_op    <= '0;
      end else if (bubble) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_imm       <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_alu_src   <= 1'b0;
         ex_wb_sel    <= '0;
         ex_alu_op    <= '0;
      end else if (!stall) begin
         ex_valid     <= id_valid;
         ex_pc        <= id_pc;
         ex_rs1_data  <= id_rs1_data;
         ex_rs2_data  <= id_rs2_data;
         ex_imm       <= id_imm;
         ex_rs1       <= id_rs1;
         ex_rs2       <= id_rs2;
         ex_rd        <= id_rd;
         ex_reg_write <= id_reg_write;
         ex_mem_read  <= id_mem_read;
         ex_mem_write <= id_mem_write;
         ex_alu_src   <= id_alu_src;
         ex_wb_sel    <= id_wb_sel;
         ex_alu_op    <= id_alu_op;
      end
   end

   fwd_sel #(.RW(RW)) u_fwd_a (
      .src             (ex_rs1),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .sel             (fwd_a_raw)
   );

   fwd_sel #(.RW(RW)) u_fwd_b (
      .src             (ex_rs2),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .sel             (fwd_b_raw)
   );

   // PC operand (AUIPC/JAL) and immediate operand override any forwarding match.
   always_comb begin
      fwd_a_sel = FWD_REG;
      fwd_b_sel = FWD_REG;
      if (ex_valid) begin
         fwd_a_sel = (ex_wb_sel == WB_PC) ? FWD_ALT : fwd_a_raw;
         fwd_b_sel = ex_alu_src ? FWD_ALT : fwd_b_raw;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized model-checked bench for id_ex_stage
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        alu_src;
      logic [1:0]  wb_sel;
      logic [3:0]  alu_op;
   } ex_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
   logic        id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0, id_alu_src = 1'b0;
   logic [1:0]  id_wb_sel = '0;
   logic [3:0]  id_alu_op = '0;
   logic        stall = 1'b0, flush = 1'b0;
   logic [4:0]  exmem_rd = '0, memwb_rd = '0;
   logic        exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;

   logic        ex_valid;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
   logic [1:0]  ex_wb_sel;
   logic [3:0]  ex_alu_op;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic        load_use_stall;

   int tests = 0;
   int fails = 0;
   ex_t m = '0;

   id_ex_stage #(.XLEN(32), .RW(5)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_alu_src(id_alu_src), .id_wb_sel(id_wb_sel), .id_alu_op(id_alu_op),
      .stall(stall), .flush(flush),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_alu_src(ex_alu_src), .ex_wb_sel(ex_wb_sel), .ex_alu_op(ex_alu_op),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .load_use_stall(load_use_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd_of(input logic [4:0] src);
      if (src == 0) return 2'd0;
      if (exmem_reg_write && exmem_rd == src) return 2'd1;
      if (memwb_reg_write && memwb_rd == src) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic exp_lus();
      return m.valid && m.mr && (m.rd != 0) && id_valid &&
             ((id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd));
   endfunction

   // Reference model of the EX-side register contents
   always @(posedge clk or posedge rst) begin
      if (rst) m = '0;
      else if (flush) m = '0;
      else if (stall) m = m;
      else if (exp_lus()) m = '0;
      else m = '{id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
                 id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_wb_sel, id_alu_op};
   end

   always @(negedge clk) begin
      logic [1:0] ea, eb;
      ea = !m.valid ? 2'd0 : (m.wb_sel == 2'd3) ? 2'd3 : fwd_of(m.rs1);
      eb = !m.valid ? 2'd0 : m.alu_src ? 2'd3 : fwd_of(m.rs2);
      chk("ex_regs", {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                      ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_wb_sel, ex_alu_op}, m);
      chk("fwd_a_sel", fwd_a_sel, ea);
      chk("fwd_b_sel", fwd_b_sel, eb);
      chk("load_use_stall", load_use_stall, exp_lus());
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fwd();
      exmem_rd = 0; memwb_rd = 0; exmem_reg_write = 0; memwb_reg_write = 0;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2, input logic mr,
                        input logic asrc, input logic [1:0] wb);
      id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_uses_rs1 = u1; id_uses_rs2 = u2; id_mem_read = mr; id_alu_src = asrc; id_wb_sel = wb;
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_reg_write = 1; id_mem_write = 0; id_alu_op = 4'($urandom_range(0, 15));
      stall = 0; flush = 0;
   endtask

   initial begin
      #12;
      chk("reset ex_valid", ex_valid, 1'b0);
      chk("reset fwd_a_sel", fwd_a_sel, 2'd0);
      chk("reset load_use_stall", load_use_stall, 1'b0);
      rst = 0;

      // dependency: EX/MEM beats MEM/WB
      issue(32'h10, 5'd5, 5'd6, 5'd1, 1, 1, 0, 0, 2'd0);
      step();
      exmem_rd = 5; exmem_reg_write = 1; memwb_rd = 5; memwb_reg_write = 1;
      #1 chk("dep fwd_a_sel", fwd_a_sel, 2'd1);
      memwb_rd = 6;
      #1 chk("memwb fwd_b_sel", fwd_b_sel, 2'd2);
      clear_fwd();

      // x0 never forwarded
      issue(32'h14, 5'd0, 5'd0, 5'd2, 1, 1, 0, 0, 2'd0);
      step();
      exmem_rd = 0; exmem_reg_write = 1;
      #1 chk("x0 fwd_b_sel", fwd_b_sel, 2'd0);
      clear_fwd();

      // load-use
      issue(32'h100, 5'd1, 5'd0, 5'd7, 1, 0, 1, 1, 2'd1);
      step();
      issue(32'h104, 5'd7, 5'd3, 5'd8, 1, 1, 0, 0, 2'd0);
      #1 chk("load_use_stall", load_use_stall, 1'b1);
      step();
      chk("lu bubble ex_valid", ex_valid, 1'b0);
      chk("lu bubble ex_reg_write", ex_reg_write, 1'b0);
      step();
      chk("lu resume ex_pc", ex_pc, 32'h104);

      // priority: flush beats stall, stall holds
      issue(32'h40, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0, 2'd0);
      step();
      chk("pre flush ex_pc", ex_pc, 32'h40);
      stall = 1; flush = 1;
      step();
      chk("stall+flush ex_valid", ex_valid, 1'b0);
      issue(32'h40, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0, 2'd0);
      step();
      stall = 1; id_pc = 32'h80;
      repeat (3) begin
         step();
         chk("stall ex_pc", ex_pc, 32'h40);
      end
      stall = 0;

      // immediate operand overrides forwarding; PC operand for A
      issue(32'h44, 5'd5, 5'd9, 5'd4, 1, 1, 0, 1, 2'd3);
      step();
      exmem_rd = 9; exmem_reg_write = 1;
      #1 chk("imm fwd_b_sel", fwd_b_sel, 2'd3);
      exmem_rd = 5;
      #1 chk("pc fwd_a_sel", fwd_a_sel, 2'd3);
      clear_fwd();

      // async reset between edges, then resume
      issue(32'h200, 5'd4, 5'd4, 5'd4, 1, 1, 1, 0, 2'd0);
      step();
      chk("pre rst ex_valid", ex_valid, 1'b1);
      rst = 1;
      #1;
      chk("rst ex_valid", ex_valid, 1'b0);
      chk("rst ex_pc", ex_pc, 32'h0);
      chk("rst fwd", {fwd_a_sel, fwd_b_sel}, 4'h0);
      chk("rst load_use_stall", load_use_stall, 1'b0);
      rst = 0;
      step();
      chk("resume ex_pc", ex_pc, 32'h200);
      chk("resume ex_valid", ex_valid, 1'b1);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         id_valid = ($urandom_range(0, 7) != 0);
         id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
         id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
         id_rd = 5'($urandom_range(0, 7));
         id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
         id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
         id_mem_write = 1'($urandom); id_alu_src = 1'($urandom);
         id_wb_sel = 2'($urandom); id_alu_op = 4'($urandom);
         stall = ($urandom_range(0, 5) == 0); flush = ($urandom_range(0, 9) == 0);
         exmem_rd = 5'($urandom_range(0, 7)); memwb_rd = 5'($urandom_range(0, 7));
         exmem_reg_write = 1'($urandom); memwb_reg_write = 1'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            #1 rst = 1;
            #1 rst = 0;
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
